// File: rtl/imem_boot_loader_if.sv
// Bundle of load, control and fetch signals between the host/core side and
// the instruction-memory boot loader.
interface imem_boot_loader_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        reload;
  logic        core_reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        fetch_fault;
  logic        ld_err;
  logic [15:0] ld_count;

  // Host / core side: drives load beats, reload and the fetch address.
  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, reload, pc,
    input  ld_ready, core_reset, instr, fetch_fault, ld_err, ld_count
  );

  // Loader side: accepts beats, answers fetches.
  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, reload, pc,
    output ld_ready, core_reset, instr, fetch_fault, ld_err, ld_count
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction memory with a valid/ready program-load port. The core is held
// in reset until the last beat has been taken; after one drain cycle the
// loaded image is served combinationally on the fetch port. Fetches of
// unloaded, misaligned or out-of-range words return a NOP and flag a fault.
module imem_boot_loader #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input logic              clk,
  input logic              reset_n,
  imem_boot_loader_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  // 33 bits so that a window ending exactly at 2^32 is still representable.
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS * 4);
  localparam logic [15:0] CNT_MAX = 16'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  // Word-aligned and inside the memory window; addresses below the base do
  // not wrap around.
  function automatic logic f_addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  // Word index of a byte address relative to the base.
  function automatic logic [AW-1:0] f_word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ld_ready;
  logic                   r_core_reset;
  logic                   r_ld_err;
  logic [15:0]            r_ld_count;
  logic [DEPTH_WORDS-1:0] r_valid;
  logic [31:0]            r_mem [DEPTH_WORDS];

  logic                   w_accept;
  logic                   w_take;
  logic                   w_good;
  logic                   w_bad;
  logic                   w_start;
  logic [AW-1:0]          w_ld_idx;
  logic [AW-1:0]          w_pc_idx;
  logic [DEPTH_WORDS-1:0] w_valid_nxt;
  logic [15:0]            w_cnt_nxt;
  logic                   w_err_nxt;

  // A beat accepted together with reload is dropped entirely.
  assign w_accept = bus.ld_valid & r_ld_ready;
  assign w_take   = w_accept & ~bus.reload;
  assign w_good   = w_take & f_addr_ok(bus.ld_addr);
  assign w_bad    = w_take & ~f_addr_ok(bus.ld_addr);
  assign w_start  = w_take & (r_state == ST_IDLE);
  assign w_ld_idx = f_word_idx(bus.ld_addr);
  assign w_pc_idx = f_word_idx(bus.pc);

  // Next-state logic of the load/run sequencer.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.reload) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A one-beat program goes straight to the drain cycle.
          if (w_accept) begin
            w_state_nxt = bus.ld_last ? ST_DRAIN : ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (w_accept && bus.ld_last) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
        ST_DRAIN: w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register; ready and core reset are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ld_ready   <= 1'b1;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_ld_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
      r_core_reset <= (w_state_nxt != ST_RUN);
    end
  end

  // Load bookkeeping: a new program clears the old one, then the beat applies.
  always_comb begin
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_ld_count;
    w_err_nxt   = r_ld_err;
    if (w_start) begin
      w_valid_nxt = '0;
      w_cnt_nxt   = 16'd0;
      w_err_nxt   = 1'b0;
    end else begin
    end
    if (w_good) begin
      w_valid_nxt[w_ld_idx] = 1'b1;
      if (w_cnt_nxt < CNT_MAX) begin
        w_cnt_nxt = w_cnt_nxt + 16'd1;
      end else begin
        w_cnt_nxt = CNT_MAX;
      end
    end else if (w_bad) begin
      w_err_nxt = 1'b1;
    end else begin
    end
  end

  // Valid bits, sticky error and good-beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= '0;
      r_ld_count <= 16'd0;
      r_ld_err   <= 1'b0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_ld_count <= w_cnt_nxt;
      r_ld_err   <= w_err_nxt;
    end
  end

  // Instruction storage; contents are qualified by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (w_good) begin
      r_mem[w_ld_idx] <= bus.ld_data;
    end
  end

  // Zero-latency fetch: NOP while the core is held, NOP plus fault on a bad fetch.
  always_comb begin
    bus.instr       = NOP_INSTR;
    bus.fetch_fault = 1'b0;
    if (r_state == ST_RUN) begin
      if (f_addr_ok(bus.pc) && r_valid[w_pc_idx]) begin
        bus.instr = r_mem[w_pc_idx];
      end else begin
        bus.fetch_fault = 1'b1;
      end
    end else begin
    end
  end

  assign bus.ld_ready   = r_ld_ready;
  assign bus.core_reset = r_core_reset;
  assign bus.ld_err     = r_ld_err;
  assign bus.ld_count   = r_ld_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: a directed vector table, hand
// sequences for error beats, held-valid after last and mid-load reset, then
// random traffic compared against an associative-array reference model.
module tb_imem_boot_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_RUN = 3;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  imem_boot_loader_if bif ();

  imem_boot_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int          m_st;
  logic [31:0] m_mem [int];
  logic        m_err;
  int          m_cnt;

  function automatic void m_reset();
    m_st = M_IDLE;
    m_mem.delete();
    m_err = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la % 4 == 0) && (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic void m_beat(input logic [31:0] a, input logic [31:0] d);
    if (in_window(a)) begin
      m_mem[int'((longint'(a) - longint'(BASE)) / 4)] = d;
      m_cnt = (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // Model behaviour at one rising edge with the inputs currently applied.
  function automatic void m_step();
    bit acc;
    acc = bif.ld_valid && (m_st == M_IDLE || m_st == M_LOAD);
    if (!reset_n) begin
      m_reset();
    end else if (bif.reload) begin
      m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: if (acc) begin
          m_mem.delete();
          m_err = 1'b0;
          m_cnt = 0;
          m_beat(bif.ld_addr, bif.ld_data);
          m_st = bif.ld_last ? M_DRAIN : M_LOAD;
        end
        M_LOAD: if (acc) begin
          m_beat(bif.ld_addr, bif.ld_data);
          if (bif.ld_last) m_st = M_DRAIN;
        end
        M_DRAIN: m_st = M_RUN;
        default: m_st = M_RUN;
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model for the current inputs.
  task automatic model_check();
    logic [31:0] e_instr;
    logic        e_flt;
    e_instr = NOP;
    e_flt   = 1'b0;
    if (m_st == M_RUN) begin
      if (in_window(bif.pc) && m_mem.exists(int'((longint'(bif.pc) - longint'(BASE)) / 4))) begin
        e_instr = m_mem[int'((longint'(bif.pc) - longint'(BASE)) / 4)];
      end else begin
        e_flt = 1'b1;
      end
    end
    chk("model.instr",       bif.instr, e_instr);
    chk("model.fetch_fault", 32'(bif.fetch_fault), 32'(e_flt));
    chk("model.ld_ready",    32'(bif.ld_ready), 32'(m_st == M_IDLE || m_st == M_LOAD));
    chk("model.core_reset",  32'(bif.core_reset), 32'(m_st != M_RUN));
    chk("model.ld_err",      32'(bif.ld_err), 32'(m_err));
    chk("model.ld_count",    32'(bif.ld_count), 32'(m_cnt));
  endtask

  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic l, input logic rl, input logic [31:0] p);
    bif.ld_valid = v;
    bif.ld_addr  = a;
    bif.ld_data  = d;
    bif.ld_last  = l;
    bif.reload   = rl;
    bif.pc       = p;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        l;
    logic        rl;
    logic [31:0] p;
    logic        e_rdy;
    logic        e_cr;
    logic [31:0] e_instr;
    logic        e_flt;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    m_reset();

    //            v     addr          data          last  rld   pc            rdy   cr    instr         flt   err   cnt
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0050_0093, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, NOP,          1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 32'h0000_0004, 32'h00A0_0113, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, NOP,          1'b0, 1'b0, 16'd1};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b1, NOP,          1'b0, 1'b0, 16'd2};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'h00A0_0113, 1'b0, 1'b0, 16'd2};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, NOP,          1'b1, 1'b0, 16'd2};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, NOP,          1'b1, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 16'd2};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, NOP,          1'b0, 1'b0, 16'd2};
    vecs[9]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, NOP,          1'b0, 1'b0, 16'd2};
    vecs[10] = '{1'b1, 32'h0000_0008, 32'h2222_2222, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, NOP,          1'b0, 1'b0, 16'd1};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b1, NOP,          1'b0, 1'b0, 16'd2};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, NOP,          1'b1, 1'b0, 16'd2};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 16'd2};

    // Reset values while reset_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ld_ready",    32'(bif.ld_ready), 32'd1);
    chk("rst.core_reset",  32'(bif.core_reset), 32'd1);
    chk("rst.instr",       bif.instr, NOP);
    chk("rst.fetch_fault", 32'(bif.fetch_fault), 32'd0);
    chk("rst.ld_err",      32'(bif.ld_err), 32'd0);
    chk("rst.ld_count",    32'(bif.ld_count), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // T1, T2, T5 as a vector table.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].l, vecs[i].rl, vecs[i].p);
      #1;
      chk($sformatf("vec%0d.ld_ready", i),    32'(bif.ld_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.core_reset", i),  32'(bif.core_reset), 32'(vecs[i].e_cr));
      chk($sformatf("vec%0d.instr", i),       bif.instr, vecs[i].e_instr);
      chk($sformatf("vec%0d.fetch_fault", i), 32'(bif.fetch_fault), 32'(vecs[i].e_flt));
      chk($sformatf("vec%0d.ld_err", i),      32'(bif.ld_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d.ld_count", i),    32'(bif.ld_count), 32'(vecs[i].e_cnt));
      tick();
    end

    // T3: out-of-range and misaligned beats, then a good last beat.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b1, 32'h0000_1000, 32'hBAD0_0001, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0000_0003, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0);
    tick();
    #1;
    chk("t3.ld_err",   32'(bif.ld_err), 32'd1);
    chk("t3.ld_count", 32'(bif.ld_count), 32'd0);
    drive(1'b1, 32'h0000_0000, 32'hABCD_0001, 1'b1, 1'b0, 32'h0);
    tick();
    // T4: valid stays high past the last beat and must not be taken.
    drive(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0004);
    #1;
    chk("t4.ld_ready_drain", 32'(bif.ld_ready), 32'd0);
    tick();
    tick();
    #1;
    chk("t4.ld_ready_run", 32'(bif.ld_ready), 32'd0);
    chk("t4.instr_pc4",    bif.instr, NOP);
    chk("t4.fault_pc4",    32'(bif.fetch_fault), 32'd1);
    chk("t4.ld_count",     32'(bif.ld_count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0000);
    #1;
    chk("t3.instr_pc0",    bif.instr, 32'hABCD_0001);
    chk("t3.core_reset",   32'(bif.core_reset), 32'd0);
    tick();

    // T6: reset_n dropped mid-load after three beats.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 32'h3000_0000 + 32'(i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("t6.ld_count",   32'(bif.ld_count), 32'd0);
    chk("t6.core_reset", 32'(bif.core_reset), 32'd1);
    chk("t6.ld_ready",   32'(bif.ld_ready), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 32'h0000_0000, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0000_0004, 32'h00A0_0113, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0004);
    tick();
    #1;
    chk("t6.instr_pc4",  bif.instr, 32'h00A0_0113);
    chk("t6.fault_pc4",  32'(bif.fetch_fault), 32'd0);
    chk("t6.ld_count2",  32'(bif.ld_count), 32'd2);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] p;
      int          r;
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 63)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'h0000_1000 + (32'($urandom_range(0, 15)) << 2);
      else             a = $urandom;
      r = int'($urandom_range(0, 9));
      if (r < 7)       p = 32'($urandom_range(0, 63)) << 2;
      else if (r == 7) p = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) p = 32'h0000_0FFC + (32'($urandom_range(0, 3)) << 2);
      else             p = $urandom;
      drive(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0), p);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
